// File: rtl/ecc_enc_pipe.sv
// ---------------------------------------------------------------------------
// ecc_enc_pipe
//   Multi-mode systematic extended-Hamming (SECDED) encoder with a two-stage
//   elastic valid/ready pipeline. The codeword size and the number of modes
//   both follow from MAX_CODEWORD_WIDTH.
//
//   Mode m: N = 2^(m+3), P = m+4 parity bits, K = N-P info bits.
//   Codeword layout: {zeros, info[K-1:0], p[P-1] (overall), p[P-2:0]}.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   in_valid/ready input handshake; in_mode selects the code, in_data is
//                  LSB-aligned info (bits at and above K are ignored)
//   out_valid/ready output handshake
//   out_data       codeword (zero when the beat carried an illegal mode)
//   out_mode       mode travelling with the beat
//   out_err        beat carried a mode >= NUM_MODES
//   beat_cnt       saturating count of legal beats delivered downstream
// ---------------------------------------------------------------------------
module ecc_enc_pipe #(
    parameter  int MAX_CODEWORD_WIDTH = 32,
    parameter  int CNT_W              = 16,
    localparam int LOG2_N             = $clog2(MAX_CODEWORD_WIDTH),
    localparam int MAX_INFO_WIDTH     = MAX_CODEWORD_WIDTH - LOG2_N - 1,
    localparam int NUM_MODES          = LOG2_N - 2,
    localparam int MODE_W             = ($clog2(NUM_MODES + 1) > 1) ? $clog2(NUM_MODES + 1) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MODE_W-1:0]             in_mode,
    input  logic [MAX_INFO_WIDTH-1:0]     in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
    output logic [MODE_W-1:0]             out_mode,
    output logic                          out_err,
    output logic [CNT_W-1:0]              beat_cnt
);

    // -----------------------------------------------------------------------
    // Elaboration-time parity masks.
    // Info bit i sits at the i-th non-power-of-2 Hamming position (3,5,6,7,9..).
    // POS_MASK[k][i] is set when that position has bit k set. The position of
    // an info bit does not depend on the mode, so one mask set serves all
    // modes; bits above K of the active mode are simply not fed in.
    // -----------------------------------------------------------------------
    typedef logic [LOG2_N-1:0][MAX_INFO_WIDTH-1:0] mask_t;

    function automatic int info_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p < 2 * MAX_CODEWORD_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic mask_t build_masks();
        mask_t m;
        int    pos;
        m = '0;
        for (int k = 0; k < LOG2_N; k++) begin
            for (int i = 0; i < MAX_INFO_WIDTH; i++) begin
                pos     = info_pos(i);
                m[k][i] = (((pos >> k) & 1) == 1);
            end
        end
        return m;
    endfunction

    localparam mask_t POS_MASK = build_masks();

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    logic                          s1_valid_q, s1_valid_d;
    logic [MAX_INFO_WIDTH-1:0]     s1_data_q,  s1_data_d;
    logic [MODE_W-1:0]             s1_mode_q,  s1_mode_d;

    logic                          out_valid_q, out_valid_d;
    logic [MAX_CODEWORD_WIDTH-1:0] out_data_q,  out_data_d;
    logic [MODE_W-1:0]             out_mode_q,  out_mode_d;
    logic                          out_err_q,   out_err_d;
    logic [CNT_W-1:0]              beat_cnt_q,  beat_cnt_d;

    logic s2_free;   // output stage can take a beat this cycle
    logic s1_adv;    // S1 beat moves into the output stage this cycle

    // -----------------------------------------------------------------------
    // Per-mode encoders, all fed from the S1 register.
    // -----------------------------------------------------------------------
    logic [NUM_MODES-1:0][MAX_CODEWORD_WIDTH-1:0] cw;

    for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
        localparam int NM = 1 << (m + 3);
        localparam int PM = m + 4;
        localparam int KM = NM - PM;

        logic [KM-1:0] info;
        logic [PM-1:0] par;

        assign info = s1_data_q[KM-1:0];

        always_comb begin
            par = '0;
            for (int k = 0; k < PM - 1; k++) begin
                par[k] = ^(MAX_INFO_WIDTH'(info) & POS_MASK[k]);
            end
            // Overall parity covers info and all lower parity bits.
            par[PM-1] = (^info) ^ (^par[PM-2:0]);
        end

        assign cw[m] = MAX_CODEWORD_WIDTH'({info, par});
    end

    // Mode select; an illegal mode matches no encoder and yields zero.
    logic [MAX_CODEWORD_WIDTH-1:0] cw_sel;
    logic                          s1_illegal;

    assign s1_illegal = (s1_mode_q >= MODE_W'(NUM_MODES));

    always_comb begin
        cw_sel = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (s1_mode_q == MODE_W'(m)) cw_sel = cw[m];
        end
    end

    // -----------------------------------------------------------------------
    // Handshake. in_ready depends only on state and out_ready, never on
    // in_valid. An empty stage never blocks, so bubbles collapse.
    // -----------------------------------------------------------------------
    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s1_adv;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        out_err_d   = out_err_q;
        beat_cnt_d  = beat_cnt_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = in_mode;
            end
        end

        // Output registers only change when the stage is free, which keeps
        // them stable under backpressure.
        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = cw_sel;
                out_mode_d = s1_mode_q;
                out_err_d  = s1_illegal;
            end
        end

        if (out_valid_q && out_ready && !out_err_q && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= '0;
            out_err_q   <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
            out_err_q   <= out_err_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign out_err   = out_err_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_ecc_enc_pipe.sv
// ---------------------------------------------------------------------------
// tb_ecc_enc_pipe
//   Directed-vector scoreboard bench for ecc_enc_pipe (N_max = 32).
//   The driver pushes the expected codeword when a beat is accepted; an
//   independent monitor pops and compares whenever a beat leaves the DUT.
// ---------------------------------------------------------------------------
module tb_ecc_enc_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [25:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
    logic        out_err;
    logic [15:0] beat_cnt;

    ecc_enc_pipe #(.MAX_CODEWORD_WIDTH(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_err   (out_err),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  m;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   npop     = 0;
    int   last_pop = 0;
    int   prev_pop = 0;
    bit   nr_seen  = 0;

    // Reference: build the codeword in Hamming positions, then repack it.
    function automatic logic [31:0] ref_enc(input int m, input logic [25:0] d);
        logic [63:0] h;
        logic [7:0]  pb;
        logic [25:0] info;
        int          n;
        int          p;
        int          idx;
        if (m >= 3) return 32'h0;
        n    = 1 << (m + 3);
        p    = m + 4;
        h    = '0;
        info = '0;
        pb   = '0;
        idx  = 0;
        for (int pos = 1; pos < n; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                h[pos]    = d[idx];
                info[idx] = d[idx];
                idx++;
            end
        end
        for (int b = 0; b < p - 1; b++)
            for (int pos = 1; pos < n; pos++)
                if (((pos >> b) & 1) == 1) pb[b] = pb[b] ^ h[pos];
        pb[p-1] = (^info) ^ (^pb);
        return (32'(info) << p) | 32'(pb);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one beat (called at posedge+1); returns at posedge+1 after the
    // accepting edge with in_valid still high.
    task automatic send(input logic [1:0] m, input logic [25:0] d,
                        input logic [31:0] exp_d, input logic exp_e);
        bit   done;
        int   w;
        exp_t e;
        done     = 0;
        w        = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = exp_d;
                e.m = m;
                e.e = exp_e;
                exp_q.push_back(e);
                done = 1;
            end else begin
                nr_seen = 1;
                w++;
                if (w > 50) begin
                    checks++;
                    failures++;
                    $display("FAIL send_timeout mode=%0d data=%0h", m, d);
                    done = 1;
                end
            end
            sync();
        end
    endtask

    // Wait until every expected beat has been seen, then let beat_cnt settle.
    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
        sync();
        @(negedge clk);
    endtask

    // Monitor: scoreboard pop plus hold-under-stall check.
    initial begin
        bit          stall_prev;
        logic [31:0] hd;
        logic [1:0]  hm;
        logic        he;
        exp_t        e;
        stall_prev = 0;
        hd = '0; hm = '0; he = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!(out_valid && out_data == hd && out_mode == hm && out_err == he)) begin
                        failures++;
                        $display("FAIL stall_hold actual=%0b/%h/%0d/%0b required=1/%h/%0d/%0b",
                                 out_valid, out_data, out_mode, out_err, hd, hm, he);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat actual=%h/%0d/%0b required=none",
                                 out_data, out_mode, out_err);
                    end else begin
                        e = exp_q.pop_front();
                        npop++;
                        prev_pop = last_pop;
                        last_pop = cyc;
                        if (out_data !== e.d || out_mode !== e.m || out_err !== e.e) begin
                            failures++;
                            $display("FAIL scoreboard actual=%h/%0d/%0b required=%h/%0d/%0b",
                                     out_data, out_mode, out_err, e.d, e.m, e.e);
                        end
                    end
                end
                stall_prev = out_valid && !out_ready;
                hd = out_data;
                hm = out_mode;
                he = out_err;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    logic [1:0]  vm [10];
    logic [25:0] vd [10];

    initial begin
        vm[0] = 2'd0; vd[0] = 26'h5;
        vm[1] = 2'd1; vd[1] = 26'h5A3;
        vm[2] = 2'd2; vd[2] = 26'h2AB_CDEF;
        vm[3] = 2'd1; vd[3] = 26'h0F0;
        vm[4] = 2'd0; vd[4] = 26'hC;
        vm[5] = 2'd2; vd[5] = 26'h000_0001;
        vm[6] = 2'd1; vd[6] = 26'h7FF;
        vm[7] = 2'd0; vd[7] = 26'h3;
        vm[8] = 2'd2; vd[8] = 26'h155_5555;
        vm[9] = 2'd1; vd[9] = 26'h400;

        rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_beat_cnt",  32'(beat_cnt),  32'd0);
        chk("rst_out_data",  out_data,       32'd0);

        // Single m0 beat and its latency through both registers.
        sync();
        send(2'd0, 26'hB, 32'h0000_00B1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_s1_only", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        drain();
        chk("cnt_after_m0", 32'(beat_cnt), 32'd1);

        // Back-to-back m0 beats leave on consecutive cycles.
        sync();
        send(2'd0, 26'hF, 32'h0000_00FF, 1'b0);
        send(2'd0, 26'h0, 32'h0000_0000, 1'b0);
        in_valid = 1'b0;
        drain();
        chk("b2b_consecutive", 32'(last_pop - prev_pop), 32'd1);
        chk("cnt_after_b2b", 32'(beat_cnt), 32'd3);

        // m1 and m2 vectors.
        sync();
        send(2'd1, 26'h001,      32'h0000_0033, 1'b0);
        send(2'd2, 26'h3FF_FFFF, 32'hFFFF_FFFF, 1'b0);
        in_valid = 1'b0;
        drain();
        chk("cnt_after_m1m2", 32'(beat_cnt), 32'd5);

        // Illegal mode: zero codeword, err flag, no count.
        sync();
        send(2'd3, 26'h155, 32'h0, 1'b1);
        in_valid = 1'b0;
        drain();
        chk("cnt_after_illegal", 32'(beat_cnt), 32'd5);

        // Ten mixed beats with out_ready low for cycles 3..6.
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        npop = 0;
        nr_seen = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(vm[i], vd[i], ref_enc(int'(vm[i]), vd[i]), 1'b0);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    sync();
                    out_ready = !(c >= 3 && c <= 6);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("stall_in_ready_fell", 32'(nr_seen), 32'd1);
        chk("mixed_beats_out",     32'(npop),    32'd10);
        chk("cnt_after_mixed",     32'(beat_cnt), 32'd10);

        // Reset with both stages full; nothing in flight may emerge.
        sync();
        out_ready = 1'b0;
        send(2'd0, 26'h6,  ref_enc(0, 26'h6),  1'b0);
        send(2'd1, 26'h2A, ref_enc(1, 26'h2A), 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        sync();
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 2'd2;
        in_data   = 26'h123_4567;
        exp_q.delete();
        sync();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_beat_cnt",  32'(beat_cnt),  32'd0);
        chk("rst2_in_ready",  32'(in_ready),  32'd1);
        repeat (6) @(negedge clk);
        chk("rst2_no_stale",  32'(out_valid), 32'd0);
        chk("rst2_cnt_hold",  32'(beat_cnt),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
